// File: rtl/fractal_sync_req.sv
// Core-side requester for a fractal synchronization node: turns PE barrier requests into
// sync pulses, tracks outstanding ids in a pending bitmap and queues wake responses.
module fractal_sync_req #(
    parameter int AGGR_WIDTH = 1,
    parameter int LVL_WIDTH  = 1,
    parameter int ID_WIDTH   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [AGGR_WIDTH-1:0] req_aggr_i,
    input  logic [ID_WIDTH-1:0]   req_id_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [LVL_WIDTH-1:0]  rsp_lvl_o,
    output logic [ID_WIDTH-1:0]   rsp_id_o,
    output logic                  rsp_error_o,
    output logic                  sync_o,
    output logic [AGGR_WIDTH-1:0] aggr_o,
    output logic [ID_WIDTH-1:0]   id_req_o,
    input  logic                  wake_i,
    input  logic [LVL_WIDTH-1:0]  lvl_i,
    input  logic [ID_WIDTH-1:0]   id_rsp_i,
    input  logic                  error_i,
    output logic [ID_WIDTH:0]     pending_cnt_o,
    output logic                  spurious_o,
    output logic                  overflow_o
);
    localparam int NUM_IDS = 2 ** ID_WIDTH;
    localparam int ENTRY_W = LVL_WIDTH + ID_WIDTH + 1;

    logic [NUM_IDS-1:0] pend;
    logic [NUM_IDS-1:0] pend_next;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ENTRY_W-1:0] fifo_tail;
    logic [ENTRY_W-1:0] head_next;
    logic [ENTRY_W-1:0] tail_next;
    logic [ENTRY_W-1:0] wake_entry;
    logic [1:0]         fifo_cnt;
    logic [1:0]         cnt_next;
    logic               accept;
    logic               wake_hit;
    logic               pop;
    logic               full;
    logic               push;

    assign req_ready_o = !pend[req_id_i];
    assign accept      = req_valid_i && req_ready_o;
    assign wake_hit    = wake_i && pend[id_rsp_i];
    assign pop         = rsp_valid_o && rsp_ready_i;
    // A pop in the same cycle frees a slot, so only a non-popping full FIFO drops.
    assign full        = (fifo_cnt == 2'd2) && !pop;
    assign push        = wake_hit && !full;
    assign wake_entry  = {lvl_i, id_rsp_i, error_i};

    assign {rsp_lvl_o, rsp_id_o, rsp_error_o} = fifo_head;

    // A same-id wake cannot hit while an accept for that id is possible, so set after clear is safe.
    always_comb begin
        pend_next = pend;
        if (wake_hit) pend_next[id_rsp_i] = 1'b0;
        if (accept)   pend_next[req_id_i] = 1'b1;
    end

    always_comb begin
        head_next = fifo_head;
        tail_next = fifo_tail;
        cnt_next  = fifo_cnt;
        if (pop) begin
            head_next = fifo_tail;
            cnt_next  = fifo_cnt - 2'd1;
        end
        if (push) begin
            if (cnt_next == 2'd0) head_next = wake_entry;
            else                  tail_next = wake_entry;
            cnt_next = cnt_next + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend          <= '0;
            pending_cnt_o <= '0;
            sync_o        <= 1'b0;
            aggr_o        <= '0;
            id_req_o      <= '0;
            spurious_o    <= 1'b0;
            overflow_o    <= 1'b0;
            fifo_head     <= '0;
            fifo_tail     <= '0;
            fifo_cnt      <= 2'd0;
            rsp_valid_o   <= 1'b0;
        end else begin
            pend          <= pend_next;
            pending_cnt_o <= pending_cnt_o + (ID_WIDTH+1)'(accept) - (ID_WIDTH+1)'(wake_hit);
            sync_o        <= accept;
            if (accept) begin
                aggr_o   <= req_aggr_i;
                id_req_o <= req_id_i;
            end
            spurious_o    <= wake_i && !pend[id_rsp_i];
            overflow_o    <= overflow_o || (wake_hit && full);
            fifo_head     <= head_next;
            fifo_tail     <= tail_next;
            fifo_cnt      <= cnt_next;
            rsp_valid_o   <= (cnt_next != 2'd0);
        end
    end
endmodule

// File: tb/tb_fractal_sync_req.sv
// Self-checking bench for fractal_sync_req: directed scenarios plus randomized traffic
// compared against a queue/array reference model.
module tb_fractal_sync_req;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rv = 1'b0, rr = 1'b0, wk = 1'b0, werr = 1'b0;
    logic [1:0] raggr = '0, rid = '0, wid = '0;
    logic [0:0] wlvl = '0;
    logic       req_ready, rsp_valid, rsp_error, sync, spurious, overflow;
    logic [0:0] rsp_lvl;
    logic [1:0] rsp_id, aggr, id_req;
    logic [2:0] pending_cnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic [0:0] lvl; logic [1:0] id; logic err; } rsp_t;
    bit         m_pend[4];
    rsp_t       m_q[$];
    logic       m_sync, m_spur, m_ovf;
    logic [1:0] m_aggr, m_idreq;
    logic       rdy_seen, exp_rdy;

    fractal_sync_req #(.AGGR_WIDTH(2), .LVL_WIDTH(1), .ID_WIDTH(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(rv), .req_ready_o(req_ready), .req_aggr_i(raggr), .req_id_i(rid),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rr), .rsp_lvl_o(rsp_lvl), .rsp_id_o(rsp_id),
        .rsp_error_o(rsp_error), .sync_o(sync), .aggr_o(aggr), .id_req_o(id_req),
        .wake_i(wk), .lvl_i(wlvl), .id_rsp_i(wid), .error_i(werr),
        .pending_cnt_o(pending_cnt), .spurious_o(spurious), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    function automatic int m_cnt();
        int c = 0;
        foreach (m_pend[k]) c += int'(m_pend[k]);
        return c;
    endfunction

    task automatic model_reset();
        foreach (m_pend[k]) m_pend[k] = 1'b0;
        m_q.delete();
        m_sync = 0; m_spur = 0; m_ovf = 0; m_aggr = '0; m_idreq = '0;
    endtask

    // Reference behaviour from the rules: who wins a barrier, what gets queued, what is dropped.
    task automatic model_step();
        bit acc, hit;
        acc = rv && !m_pend[rid];
        hit = wk && m_pend[wid];
        m_spur = wk && !m_pend[wid];
        if (rr && m_q.size() > 0) m_q.delete(0);
        if (hit) begin
            if (m_q.size() < 2) m_q.push_back('{wlvl, wid, werr});
            else m_ovf = 1'b1;
            m_pend[wid] = 1'b0;
        end
        if (acc) begin
            m_pend[rid] = 1'b1;
            m_aggr = raggr;
            m_idreq = rid;
        end
        m_sync = acc;
    endtask

    task automatic cyc(input logic v, input logic [1:0] a, input logic [1:0] i, input logic r,
                       input logic w, input logic l, input logic [1:0] wi, input logic e);
        @(negedge clk);
        rv = v; raggr = a; rid = i; rr = r; wk = w; wlvl = l; wid = wi; werr = e;
        #1;
        rdy_seen = req_ready;
        exp_rdy = !m_pend[i];
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rv = 0; rr = 0; wk = 0; werr = 0; raggr = '0; rid = '0; wid = '0; wlvl = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_vec++; if (sync !== 1'b0) begin n_err++; $display("FAIL reset_sync got %0b want 0", sync); end
        n_vec++; if (aggr !== 2'b00 || id_req !== 2'b00) begin n_err++; $display("FAIL reset_aggr_id got %0b/%0d want 0/0", aggr, id_req); end
        n_vec++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", pending_cnt); end
        n_vec++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_lvl !== 1'b0 || rsp_error !== 1'b0) begin
            n_err++; $display("FAIL reset_rsp got v%0b id%0d l%0d e%0b want all 0", rsp_valid, rsp_id, rsp_lvl, rsp_error); end
        n_vec++; if (spurious !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_flags got %0b%0b want 00", spurious, overflow); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", req_ready); end
    endtask

    task automatic test_accept_wake();
        cyc(0, 2'b00, 2'd0, 0, 0, 0, 2'd0, 0);
        cyc(1, 2'b10, 2'd1, 0, 0, 0, 2'd0, 0);
        n_vec++; if (sync !== 1'b1 || aggr !== 2'b10 || id_req !== 2'd1) begin
            n_err++; $display("FAIL accept_sync got s%0b a%0b id%0d want s1 a10 id1", sync, aggr, id_req); end
        n_vec++; if (pending_cnt !== 3'd1) begin n_err++; $display("FAIL accept_cnt got %0d want 1", pending_cnt); end
        cyc(0, 2'b00, 2'd1, 0, 0, 0, 2'd0, 0);
        n_vec++; if (rdy_seen !== 1'b0) begin n_err++; $display("FAIL ready_pending_id got %0b want 0", rdy_seen); end
        n_vec++; if (sync !== 1'b0 || aggr !== 2'b10 || id_req !== 2'd1) begin
            n_err++; $display("FAIL sync_one_cycle got s%0b a%0b id%0d want s0 a10 id1", sync, aggr, id_req); end
        cyc(0, 2'b00, 2'd0, 0, 0, 0, 2'd0, 0);
        n_vec++; if (rdy_seen !== 1'b1) begin n_err++; $display("FAIL ready_free_id got %0b want 1", rdy_seen); end
        cyc(0, 2'b00, 2'd0, 0, 1, 1, 2'd1, 0);
        n_vec++; if (rsp_valid !== 1'b1 || rsp_lvl !== 1'b1 || rsp_id !== 2'd1 || rsp_error !== 1'b0) begin
            n_err++; $display("FAIL wake_rsp got v%0b l%0d id%0d e%0b want v1 l1 id1 e0", rsp_valid, rsp_lvl, rsp_id, rsp_error); end
        n_vec++; if (pending_cnt !== 3'd0 || spurious !== 1'b0) begin
            n_err++; $display("FAIL wake_cnt got cnt%0d sp%0b want cnt0 sp0", pending_cnt, spurious); end
        cyc(1, 2'b01, 2'd1, 1, 0, 0, 2'd0, 0);
        n_vec++; if (rdy_seen !== 1'b1 || sync !== 1'b1 || pending_cnt !== 3'd1 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL reaccept got rdy%0b s%0b cnt%0d v%0b want 1 1 1 0", rdy_seen, sync, pending_cnt, rsp_valid); end
    endtask

    task automatic test_spurious();
        apply_reset();
        cyc(0, 2'b00, 2'd0, 0, 1, 0, 2'd0, 0);
        n_vec++; if (spurious !== 1'b1 || rsp_valid !== 1'b0 || pending_cnt !== 3'd0) begin
            n_err++; $display("FAIL spurious_wake got sp%0b v%0b cnt%0d want 1 0 0", spurious, rsp_valid, pending_cnt); end
        cyc(0, 2'b00, 2'd0, 0, 0, 0, 2'd0, 0);
        n_vec++; if (spurious !== 1'b0) begin n_err++; $display("FAIL spurious_pulse got %0b want 0", spurious); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 4; i++) cyc(1, 2'b11, 2'(i), 0, 0, 0, 2'd0, 0);
        n_vec++; if (pending_cnt !== 3'd4) begin n_err++; $display("FAIL ovf_fill_cnt got %0d want 4", pending_cnt); end
        cyc(0, 2'b00, 2'd0, 0, 1, 0, 2'd2, 0);
        cyc(0, 2'b00, 2'd0, 0, 1, 1, 2'd0, 1);
        n_vec++; if (overflow !== 1'b0 || pending_cnt !== 3'd2) begin
            n_err++; $display("FAIL ovf_two_entries got ovf%0b cnt%0d want 0 2", overflow, pending_cnt); end
        cyc(0, 2'b00, 2'd0, 0, 1, 0, 2'd3, 0);
        n_vec++; if (overflow !== 1'b1 || pending_cnt !== 3'd1 || rsp_id !== 2'd2 || rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL ovf_drop got ovf%0b cnt%0d id%0d v%0b want 1 1 2 1", overflow, pending_cnt, rsp_id, rsp_valid); end
        cyc(0, 2'b00, 2'd0, 1, 0, 0, 2'd0, 0);
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_lvl !== 1'b1 || rsp_error !== 1'b1) begin
            n_err++; $display("FAIL ovf_second got v%0b id%0d l%0d e%0b want 1 0 1 1", rsp_valid, rsp_id, rsp_lvl, rsp_error); end
        cyc(0, 2'b00, 2'd0, 1, 0, 0, 2'd0, 0);
        n_vec++; if (rsp_valid !== 1'b0 || overflow !== 1'b1) begin
            n_err++; $display("FAIL ovf_drain got v%0b ovf%0b want 0 1", rsp_valid, overflow); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        cyc(1, 2'b01, 2'd1, 0, 0, 0, 2'd0, 0);
        cyc(1, 2'b10, 2'd2, 0, 1, 0, 2'd1, 1);
        n_vec++; if (pending_cnt !== 3'd1 || sync !== 1'b1 || id_req !== 2'd2) begin
            n_err++; $display("FAIL simul_accept got cnt%0d s%0b id%0d want 1 1 2", pending_cnt, sync, id_req); end
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_error !== 1'b1) begin
            n_err++; $display("FAIL simul_rsp got v%0b id%0d e%0b want 1 1 1", rsp_valid, rsp_id, rsp_error); end
        cyc(1, 2'b11, 2'd3, 0, 1, 0, 2'd3, 0);
        n_vec++; if (spurious !== 1'b1 || pending_cnt !== 3'd2 || sync !== 1'b1 || id_req !== 2'd3) begin
            n_err++; $display("FAIL same_id got sp%0b cnt%0d s%0b id%0d want 1 2 1 3", spurious, pending_cnt, sync, id_req); end
    endtask

    task automatic test_reset_mid();
        rv = 0; rr = 0; wk = 0;
        n_vec++; if (pending_cnt !== 3'd2 || rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL mid_precond got cnt%0d v%0b want 2 1", pending_cnt, rsp_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (sync !== 1'b0 || aggr !== 2'b00 || id_req !== 2'd0 || pending_cnt !== 3'd0 || rsp_valid !== 1'b0 ||
                     rsp_id !== 2'd0 || rsp_error !== 1'b0 || spurious !== 1'b0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL mid_reset got s%0b a%0b id%0d cnt%0d v%0b rid%0d want all 0", sync, aggr, id_req, pending_cnt, rsp_valid, rsp_id); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cyc(0, 2'b00, 2'd0, 0, 1, 0, 2'd2, 0);
        n_vec++; if (spurious !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL forgotten_id got sp%0b v%0b want 1 0", spurious, rsp_valid); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            cyc(1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), 1'($urandom));
            n_vec++; if (rdy_seen !== exp_rdy) begin n_err++; $display("FAIL rnd_ready cyc%0d got %0b want %0b", n, rdy_seen, exp_rdy); end
            n_vec++; if (sync !== m_sync || aggr !== m_aggr || id_req !== m_idreq) begin
                n_err++; $display("FAIL rnd_sync cyc%0d got %0b/%0b/%0d want %0b/%0b/%0d", n, sync, aggr, id_req, m_sync, m_aggr, m_idreq); end
            n_vec++; if (int'(pending_cnt) != m_cnt()) begin n_err++; $display("FAIL rnd_cnt cyc%0d got %0d want %0d", n, pending_cnt, m_cnt()); end
            n_vec++; if (spurious !== m_spur || overflow !== m_ovf) begin
                n_err++; $display("FAIL rnd_flags cyc%0d got %0b%0b want %0b%0b", n, spurious, overflow, m_spur, m_ovf); end
            n_vec++; if (rsp_valid !== (m_q.size() > 0)) begin
                n_err++; $display("FAIL rnd_valid cyc%0d got %0b want %0b", n, rsp_valid, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                n_vec++; if (rsp_lvl !== m_q[0].lvl || rsp_id !== m_q[0].id || rsp_error !== m_q[0].err) begin
                    n_err++; $display("FAIL rnd_head cyc%0d got l%0d id%0d e%0b want l%0d id%0d e%0b", n, rsp_lvl, rsp_id, rsp_error, m_q[0].lvl, m_q[0].id, m_q[0].err); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_accept_wake();
        test_spurious();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fractal_sync_req.md
# fractal_sync_req

Core-side requester that sits directly upstream of a fractal synchronization node and drives its master-side sync port. It accepts barrier requests from a processing element over a valid/ready handshake and issues one-cycle sync pulses. It tracks outstanding barrier ids in a pending bitmap, matches returning wakes against that bitmap, and buffers responses in a 2-entry FIFO until the processing element consumes them.

## Interface
- AGGR_WIDTH, 1: width of aggr; leading 1 marks the root level of the request.
- LVL_WIDTH, 1: width of the wake-origin level.
- ID_WIDTH, 1: barrier id width; the pending bitmap has 2^ID_WIDTH entries.
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  PE request valid.
- req_ready_o  out  1  request accepted when valid and ready are both high.
- req_aggr_i  in  AGGR_WIDTH  aggregation mask of the request.
- req_id_i  in  ID_WIDTH  barrier id of the request.
- rsp_valid_o  out  1  response available at the FIFO head.
- rsp_ready_i  in  1  PE consumes the head entry.
- rsp_lvl_o  out  LVL_WIDTH  level of the head response.
- rsp_id_o  out  ID_WIDTH  id of the head response.
- rsp_error_o  out  1  error flag of the head response.
- sync_o  out  1  sync pulse toward the node.
- aggr_o  out  AGGR_WIDTH  aggr toward the node.
- id_req_o  out  ID_WIDTH  id_req toward the node.
- wake_i  in  1  wake from the node.
- lvl_i  in  LVL_WIDTH  wake origin level.
- id_rsp_i  in  ID_WIDTH  wake barrier id.
- error_i  in  1  node error, qualified by wake_i.
- pending_cnt_o  out  ID_WIDTH+1  number of set pending bits.
- spurious_o  out  1  one-cycle pulse on a wake for a non-pending id.
- overflow_o  out  1  sticky; a wake was dropped because the FIFO was full.

## Operation
- req_ready_o = !pend[req_id_i], computed combinationally from the registered bitmap. It does not depend on FIFO state.
- Accept in cycle N:
  - pend[req_id_i] is set at the N edge.
  - sync_o=1 in cycle N+1, with aggr_o/id_req_o registered copies of the request. sync_o is high for exactly one cycle unless another request is accepted in N+1.
- Back-to-back accepts with distinct ids yield one sync pulse per cycle.
- Between pulses, aggr_o/id_req_o hold their last values and sync_o is 0.
- aggr=0 is forwarded unchanged. Detecting it is the node's job; the node answers with error.
- Wake in cycle N with pend[id_rsp_i]=1:
  - pend[id_rsp_i] is cleared at the N edge.
  - {lvl_i, id_rsp_i, error_i} is pushed into the FIFO.
  - The bit is cleared even when error_i=1.
- Wake with pend[id_rsp_i]=0: spurious_o=1 in cycle N+1, no push, bitmap unchanged.
- FIFO full at a valid wake:
  - The entry is dropped and overflow_o is set; it stays set until reset.
  - pend is still cleared, so the id does not deadlock.
  - FIFO full means 2 entries with no pop in the same cycle. A pop in the same cycle frees a slot and the push succeeds.
- Simultaneous accept of id X and wake for id X in the same cycle: pend[X] must have been 0 for the accept, so the wake is spurious.
- Simultaneous accept of id X and wake for id Y (Y≠X): both take effect. pending_cnt_o is unchanged net.
- Wake clearing id X in cycle N: a request for X can be accepted at the earliest in N+1.
- pending_cnt_o is a registered counter: +1 on accept, −1 on a valid wake, net 0 when both occur. It always equals popcount(pend).
- FIFO: 2 entries, head registered, first-in first-out. Responses appear in wake order, not request order.

## Timing
- Reset (asynchronous, any cycle, including mid-operation):
  - sync_o=0, aggr_o=0, id_req_o=0.
  - pend cleared, pending_cnt_o=0.
  - FIFO empty, rsp_valid_o=0, rsp_lvl_o/rsp_id_o/rsp_error_o=0.
  - spurious_o=0, overflow_o=0.
  - In-flight barriers are forgotten; later wakes for them report spurious.
- Request-to-sync latency: 1 cycle.
- Wake-to-rsp_valid_o latency: 1 cycle when the FIFO is empty.
- rsp_* is stable while rsp_valid_o=1 and rsp_ready_i=0.
- Pop in cycle N: the next entry (if any) is presented in N+1.
- Wake and pop in the same cycle with 1 entry: rsp_valid_o stays 1 and the new entry is at the head in N+1.
- All outputs are registered except req_ready_o.

## Test plan
- Reset, accept id=1 with aggr=2'b10 (AGGR_WIDTH=2) at cycle 3 -> sync_o=1, aggr_o=2'b10, id_req_o=1 in cycle 4 only; pending_cnt_o=1; req_ready_o=0 for id 1 and 1 for id 0.
- Pending id=1, wake id_rsp=1, lvl=1, error=0 at cycle 10 -> rsp_valid_o=1 with lvl 1, id 1, error 0 in cycle 11; pending_cnt_o=0; new id=1 request accepted in cycle 11.
- Wake id=0 with nothing pending -> spurious_o=1 for one cycle, rsp_valid_o stays 0, pending_cnt_o stays 0.
- Ids 0..3 pending (ID_WIDTH=2), rsp_ready_i=0, wakes for 2, 0, 3 -> FIFO holds 2 then 0, overflow_o=1, pending_cnt_o=1; releasing rsp_ready_i yields ids 2 then 0.
- Accept id 2 and wake id 1 (pending) in the same cycle -> pending_cnt_o unchanged; sync for id 2 next cycle; response for id 1 next cycle.
- Assert rst_ni low with 2 pending ids and 1 FIFO entry -> all outputs return to reset values immediately; a later wake for a former id gives spurious_o=1.
